// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and byte-memory signals around mem_port_arbiter.
// Latency: none, wires only.
// Backpressure: req/ack handshakes toward the core, mem_ready stalls toward memory.
// Ports: if_* fetch port, ls_* load/store port, rdata shared read data,
//        mem_* byte-wide external memory port.
// Modports: slave = the arbiter, master = core/memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_err;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_ack;
  logic              ls_err;

  logic [31:0]       rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;
  logic [7:0]        mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  mem_ready, mem_rdata,
    output if_ack, if_err, ls_ack, ls_err, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output mem_ready, mem_rdata,
    input  if_ack, if_err, ls_ack, ls_err, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between fetch and LSU, LSU priority with fetch anti-starvation.
// Latency: with mem_ready tied high, ack 2/3/5 cycles after req for byte/half/word.
// Backpressure: mem_ready low holds the current byte; requesters wait for their ack pulse.
// Ports: clk, rst_n (async active-low), bus (mem_port_arbiter_if.slave).
// Optional: define MEM_TIMEOUT_EN to abort a byte that waits TIMEOUT_CYCLES
//           cycles without mem_ready (ack with err=1, rdata=0).
module mem_port_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int MAX_STREAK     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state;
  logic                grant_ls;   // 1: current transaction belongs to the LSU
  logic                cur_we;
  logic [ADDR_W-1:0]   base_addr;
  logic [31:0]         cur_wdata;
  logic [1:0]          byte_idx;
  logic [1:0]          last_idx;   // index of the final byte: 0, 1 or 3
  logic [STREAK_W-1:0] streak;

  logic                if_ack_q, ls_ack_q, if_err_q, ls_err_q;
  logic [31:0]         rdata_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;

  logic                streak_full;
  logic                pick_ls;
  logic [1:0]          ls_last_idx;
  logic [1:0]          next_idx;
  logic [ADDR_W-1:0]   next_addr;
  logic                tmo_hit;

  assign streak_full = (streak == STREAK_W'(MAX_STREAK));
  // LSU wins unless fetch has been passed over MAX_STREAK times in a row.
  assign pick_ls     = bus.ls_req && !(bus.if_req && streak_full);
  assign ls_last_idx = (bus.ls_size == 2'd0) ? 2'd0 :
                       (bus.ls_size == 2'd1) ? 2'd1 : 2'd3;
  assign next_idx    = byte_idx + 2'd1;
  // Address arithmetic wraps naturally at ADDR_W bits.
  assign next_addr   = base_addr + ADDR_W'(next_idx);

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  assign tmo_hit = !bus.mem_ready && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_ls    <= 1'b0;
      cur_we      <= 1'b0;
      base_addr   <= '0;
      cur_wdata   <= '0;
      byte_idx    <= '0;
      last_idx    <= '0;
      streak      <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.ls_req) begin
            state     <= XFER;
            byte_idx  <= '0;
            rdata_q   <= '0;
            mem_req_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            if (pick_ls) begin
              grant_ls    <= 1'b1;
              base_addr   <= bus.ls_addr;
              cur_we      <= bus.ls_we;
              cur_wdata   <= bus.ls_wdata;
              last_idx    <= ls_last_idx;
              mem_addr_q  <= bus.ls_addr;
              mem_we_q    <= bus.ls_we;
              mem_wdata_q <= bus.ls_wdata[7:0];
              // Only grants made over a waiting fetch count toward the streak.
              if (bus.if_req && !streak_full) begin
                streak <= streak + STREAK_W'(1);
              end
            end else begin
              grant_ls    <= 1'b0;
              base_addr   <= bus.if_addr;
              cur_we      <= 1'b0;
              cur_wdata   <= '0;
              last_idx    <= 2'd3;
              mem_addr_q  <= bus.if_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              streak      <= '0;
            end
          end
        end

        XFER: begin
          if (bus.mem_ready) begin
            if (!cur_we) begin
              rdata_q[8*byte_idx +: 8] <= bus.mem_rdata;
            end
            if (byte_idx == last_idx) begin
              state       <= DONE;
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              if_ack_q    <= !grant_ls;
              ls_ack_q    <= grant_ls;
            end else begin
              // mem_req stays high; the next byte goes out on the following cycle.
              byte_idx    <= next_idx;
              mem_addr_q  <= next_addr;
              mem_wdata_q <= cur_wdata[8*next_idx +: 8];
`ifdef MEM_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
            end
          end else if (tmo_hit) begin
            // Abandon the remaining bytes; partial read data is discarded.
            state       <= DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            if_ack_q    <= !grant_ls;
            ls_ack_q    <= grant_ls;
            if_err_q    <= !grant_ls;
            ls_err_q    <= grant_ls;
          end else begin
`ifdef MEM_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end

        DONE: begin
          state    <= IDLE;
          if_ack_q <= 1'b0;
          ls_ack_q <= 1'b0;
          if_err_q <= 1'b0;
          ls_err_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign bus.if_err    = if_err_q;
  assign bus.ls_err    = ls_err_q;
`else
  assign bus.if_err    = 1'b0;
  assign bus.ls_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, byte sequencing, arbitration, stall, reset, timeout.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: mem_ready driven directly by the scenario tasks.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [7:0] mem_model [0:255];

  mem_port_arbiter_if #(.ADDR_W(24)) bus ();

  mem_port_arbiter #(
    .ADDR_W(24),
    .MAX_STREAK(2),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Byte memory: entry i holds 0x11*(i+1), so 0x100..0x103 read 11,22,33,44.
  assign bus.mem_rdata = mem_model[bus.mem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_size  = 2'd0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    bus.mem_ready = 1'b1;
  endtask

  // Runs until n acks are seen (or the budget expires); bit k of order is 1 for an LSU grant.
  task automatic collect_grants(input int n, output logic [7:0] order, output int got,
                                output int both);
    order = '0;
    got   = 0;
    both  = 0;
    for (int c = 0; c < 300 && got < n; c++) begin
      tick();
      if (bus.if_ack && bus.ls_ack) both++;
      if (bus.ls_ack) begin
        order[got] = 1'b1;
        got++;
      end else if (bus.if_ack) begin
        order[got] = 1'b0;
        got++;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL reset_mem_ctl: req=%b we=%b want 0 0", bus.mem_req, bus.mem_we);
    end
    total++;
    if (bus.mem_addr !== 24'h0 || bus.mem_wdata !== 8'h0) begin
      bad++; $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata);
    end
    total++;
    if (bus.if_ack !== 1'b0 || bus.ls_ack !== 1'b0 || bus.if_err !== 1'b0 || bus.ls_err !== 1'b0) begin
      bad++; $display("FAIL reset_acks: got %b%b%b%b want 0000",
                      bus.if_ack, bus.ls_ack, bus.if_err, bus.ls_err);
    end
    total++;
    if (bus.rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_read();
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_size = 2'd2;
    bus.ls_addr = 24'h000100;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.ls_ack !== 1'b0 ||
          bus.mem_addr !== 24'h000100 + 24'(k - 1)) begin
        bad++; $display("FAIL word_read_byte%0d: req=%b we=%b ack=%b addr=%h want 1 0 0 %h", k,
                        bus.mem_req, bus.mem_we, bus.ls_ack, bus.mem_addr, 24'h000100 + 24'(k - 1));
      end
    end
    tick();
    total++;
    if (bus.ls_ack !== 1'b1 || bus.if_ack !== 1'b0 || bus.ls_err !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL word_read_ack: ls_ack=%b if_ack=%b err=%b mem_req=%b want 1 0 0 0",
                      bus.ls_ack, bus.if_ack, bus.ls_err, bus.mem_req);
    end
    total++;
    if (bus.rdata !== 32'h44332211) begin
      bad++; $display("FAIL word_read_data: got %h want 44332211", bus.rdata);
    end
    bus.ls_req = 1'b0;
    tick();
    total++;
    if (bus.ls_ack !== 1'b0 || bus.rdata !== 32'h44332211) begin
      bad++; $display("FAIL word_read_after: ack=%b rdata=%h want 0 44332211", bus.ls_ack, bus.rdata);
    end
    tick();
  endtask

  task automatic test_half_write_wrap();
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'd1;
    bus.ls_addr  = 24'hFFFFFF;
    bus.ls_wdata = 32'hAABBCCDD;
    tick();
    // Changing the request after grant must not affect the transfer.
    bus.ls_addr  = 24'h123456;
    bus.ls_wdata = 32'h0;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 24'hFFFFFF ||
        bus.mem_wdata !== 8'hDD) begin
      bad++; $display("FAIL half_write_b0: req=%b we=%b addr=%h data=%h want 1 1 ffffff dd",
                      bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 24'h000000 ||
        bus.mem_wdata !== 8'hCC) begin
      bad++; $display("FAIL half_write_b1: req=%b we=%b addr=%h data=%h want 1 1 000000 cc",
                      bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    total++;
    if (bus.ls_ack !== 1'b1 || bus.rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL half_write_ack: ack=%b rdata=%h mem_req=%b want 1 0 0",
                      bus.ls_ack, bus.rdata, bus.mem_req);
    end
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_arbitration();
    logic [7:0] order;
    int         got;
    int         both;
    bus.if_req  = 1'b1;
    bus.if_addr = 24'h000000;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_size = 2'd0;
    bus.ls_addr = 24'h000002;
    collect_grants(6, order, got, both);
    total++;
    if (got !== 6) begin
      bad++; $display("FAIL arb_count: got %0d acks want 6", got);
    end
    total++;
    if (order[5:0] !== 6'b011011) begin
      bad++; $display("FAIL arb_order: got %b want 011011 (bit0 first, 1=LSU)", order[5:0]);
    end
    total++;
    if (both !== 0) begin
      bad++; $display("FAIL arb_both_ack: got %0d cycles want 0", both);
    end
    total++;
    if (bus.if_ack !== 1'b1 || bus.rdata !== 32'h44332211) begin
      bad++; $display("FAIL arb_fetch_data: if_ack=%b rdata=%h want 1 44332211", bus.if_ack, bus.rdata);
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stall();
    bus.mem_ready = 1'b0;
    bus.ls_req    = 1'b1;
    bus.ls_we     = 1'b0;
    bus.ls_size   = 2'd0;
    bus.ls_addr   = 24'h000001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 24'h000001 || bus.ls_ack !== 1'b0 ||
          bus.ls_err !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: req=%b addr=%h ack=%b err=%b want 1 000001 0 0", k,
                        bus.mem_req, bus.mem_addr, bus.ls_ack, bus.ls_err);
      end
    end
    bus.mem_ready = 1'b1;
    tick();
    total++;
    if (bus.ls_ack !== 1'b1 || bus.rdata !== 32'h00000022 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL stall_ack: ack=%b rdata=%h mem_req=%b want 1 00000022 0",
                      bus.ls_ack, bus.rdata, bus.mem_req);
    end
    bus.ls_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] order;
    int         got;
    int         both;
    // Both requesting: LSU wins and the streak moves to 1 before reset hits.
    bus.if_req   = 1'b1;
    bus.if_addr  = 24'h000000;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'd2;
    bus.ls_addr  = 24'h000010;
    bus.ls_wdata = 32'h01020304;
    tick();
    total++;
    if (bus.mem_addr !== 24'h000010 || bus.mem_wdata !== 8'h04 || bus.mem_we !== 1'b1) begin
      bad++; $display("FAIL rst_write_b0: addr=%h data=%h we=%b want 000010 04 1",
                      bus.mem_addr, bus.mem_wdata, bus.mem_we);
    end
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.ls_ack !== 1'b0 || bus.if_ack !== 1'b0) begin
      bad++; $display("FAIL rst_mid_drop: req=%b we=%b ls_ack=%b if_ack=%b want 0 0 0 0",
                      bus.mem_req, bus.mem_we, bus.ls_ack, bus.if_ack);
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (bus.mem_req !== 1'b0 || bus.ls_ack !== 1'b0 || bus.if_ack !== 1'b0) begin
      bad++; $display("FAIL rst_idle: req=%b ls_ack=%b if_ack=%b want 0 0 0",
                      bus.mem_req, bus.ls_ack, bus.if_ack);
    end
    // A cleared streak gives LSU, LSU, fetch again.
    bus.if_req  = 1'b1;
    bus.ls_req  = 1'b1;
    bus.ls_size = 2'd0;
    bus.ls_addr = 24'h000002;
    collect_grants(3, order, got, both);
    total++;
    if (got !== 3 || order[2:0] !== 3'b011 || both !== 0) begin
      bad++; $display("FAIL rst_streak: got=%0d order=%b both=%0d want 3 011 0", got, order[2:0], both);
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    tick();
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    bus.mem_ready = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 24'h000040;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (bus.mem_req !== 1'b1 || bus.if_ack !== 1'b0) begin
        bad++; $display("FAIL timeout_wait%0d: req=%b ack=%b want 1 0", k, bus.mem_req, bus.if_ack);
      end
    end
    tick();
    total++;
    if (bus.if_ack !== 1'b1 || bus.if_err !== 1'b1 || bus.rdata !== 32'h0 || bus.mem_req !== 1'b0 ||
        bus.ls_ack !== 1'b0) begin
      bad++; $display("FAIL timeout_ack: ack=%b err=%b rdata=%h mem_req=%b ls_ack=%b want 1 1 0 0 0",
                      bus.if_ack, bus.if_err, bus.rdata, bus.mem_req, bus.ls_ack);
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(17 * (i + 1));
    rst_n = 1'b0;
    test_reset();
    test_word_read();
    test_half_write_wrap();
    test_arbitration();
    test_stall();
    test_reset_mid_write();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 8-bit external memory byte port of the MCU between instruction fetch and load/store. Arbitrates the two requesters with LSU priority and a fetch anti-starvation limit. Sequences each granted 8/16/32-bit access into little-endian byte transfers. Sits between the core's fetch/LSU units and the uio-pin memory interface logic.

Parameters:
ADDR_W, 24, byte address width on all address ports
MAX_STREAK, 2, max consecutive LSU grants while fetch is pending before fetch is forced
TIMEOUT_CYCLES, 255, per-byte wait limit (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch byte address (always word access)
if_ack  out  1  one-cycle completion pulse to fetch
if_err  out  1  timeout flag, valid with if_ack
ls_req  in  1  LSU request, held until ls_ack
ls_we  in  1  1=write, 0=read
ls_size  in  2  0=byte, 1=half, 2/3=word
ls_addr  in  ADDR_W  LSU byte address
ls_wdata  in  32  write data, low bytes used
ls_ack  out  1  one-cycle completion pulse to LSU
ls_err  out  1  timeout flag, valid with ls_ack
rdata  out  32  read data, shared, valid with if_ack/ls_ack
mem_req  out  1  byte transfer request
mem_we  out  1  byte write enable
mem_addr  out  ADDR_W  byte address
mem_wdata  out  8  byte write data
mem_ready  in  1  byte transfer complete this cycle
mem_rdata  in  8  read byte, valid when mem_ready=1

Behaviour:
- Reset (async, immediate): state IDLE, streak=0; all outputs 0; mem_req drops immediately even mid-transfer.
- States: IDLE -> XFER -> DONE -> IDLE.
- IDLE: on any request, latch winner's addr/we/size/wdata, set byte_idx=0, clear rdata accumulator, go XFER. No request: stay.
- Arbitration in IDLE: ls only -> LSU; if only -> fetch; both -> LSU unless streak==MAX_STREAK, then fetch. Streak increments on LSU grant with if_req high; clears on any fetch grant; saturates at MAX_STREAK.
- XFER: mem_req=1, mem_addr=base+byte_idx (wraps mod 2^ADDR_W), mem_we=latched we (fetch always 0), mem_wdata=wdata[8*byte_idx+:8]. Outputs stable until mem_ready. On mem_ready: read byte stored to rdata[8*byte_idx+:8]; if last byte (count 1/2/4) go DONE, else byte_idx+1, mem_req stays high with new address next cycle.
- DONE: mem_req=0; pulse ack of granted requester for exactly one cycle; rdata valid, upper unused bytes zero (no sign extension); writes leave rdata=0. Next cycle IDLE.
- rdata holds value until next transaction starts.
- Latency with mem_ready tied 1, word access: req high cycle N -> mem_req cycles N+1..N+4 -> ack cycle N+5 -> IDLE N+6. Byte: ack N+2.
- Requesters drop req the cycle after ack; req still high in IDLE starts a new transaction.
- Requester dropping req mid-transaction: ignored, transaction completes and acks (no torn writes).
- Requests changing addr/data after grant: ignored (latched).
- No alignment check; misaligned accesses proceed byte-wise.
- Fetch and LSU acks never assert in the same cycle.

Optional Feature:
MEM_TIMEOUT_EN: defined -> per-byte counter cleared on entering each byte; if mem_ready not seen within TIMEOUT_CYCLES cycles of XFER, abort remaining bytes, go DONE with ack and err=1, rdata=0. Not defined -> if_err/ls_err tied 0, XFER waits indefinitely, no counter logic.

Test Plan:
- LSU word read ls_addr=0x000100, mem_ready=1, memory bytes 11,22,33,44 -> mem_addr 0x100..0x103, ls_ack at N+5, rdata=0x44332211.
- LSU halfword write ls_addr=0xFFFFFF, wdata=0xAABBCCDD -> bytes DD@0xFFFFFF, CC@0x000000, mem_we=1, ls_ack, rdata=0.
- if_req and ls_req both held continuously, MAX_STREAK=2 -> grant order LSU,LSU,fetch,LSU,LSU,fetch.
- mem_ready stalled 3 cycles per byte on byte read -> mem_req/addr stable during stall, ack 1 cycle after ready, rdata upper 24 bits 0.
- rst_n low mid-word-write after byte 1 -> mem_req 0 same cycle, no ack, after release IDLE, streak 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never high -> if_ack with if_err=1, rdata=0, mem_req low in DONE.
